// File: rtl/paint_pkg.sv
// Shared geometry, colour and state definitions for the paint writer.
package paint_pkg;

    localparam int H_RES    = 160;
    localparam int V_RES    = 120;
    localparam int FB_DEPTH = 19200;
    localparam int ADDR_W   = 15;

    localparam logic [7:0]        BG_COLOR  = 8'h00;
    localparam logic [ADDR_W-1:0] LAST_ADDR = 15'(FB_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAINT = 2'd1,
        ST_CLEAR = 2'd2
    } paint_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Pixel-to-framebuffer address mapping with an in-bounds flag.
// Coordinates are 9 bits so that x+1 / y+1 of the brush cannot wrap.
module fb_addr_calc
    import paint_pkg::*;
(
    input  logic [8:0]        i_x,
    input  logic [8:0]        i_y,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_bounds
);

    logic [ADDR_W-1:0] w_x15;
    logic [ADDR_W-1:0] w_y15;

    assign w_x15 = {6'd0, i_x};
    assign w_y15 = {6'd0, i_y};

    // y*160 as two shifts; only meaningful when the pixel is on screen
    assign o_addr      = (w_y15 << 7) + (w_y15 << 5) + w_x15;
    assign o_in_bounds = (i_x < 9'(H_RES)) && (i_y < 9'(V_RES));

endmodule

// File: rtl/paint_writer.sv
// Paint/clear write sequencer for a 160x120 framebuffer.
// Optional macro PAINT_BRUSH2X2_EN widens each paint to a 2x2 brush.
module paint_writer
    import paint_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        PEN_DOWN,
    input  logic        CLEAR,
    input  logic [7:0]  xCoord,
    input  logic [7:0]  yCoord,
    input  logic [7:0]  RGBw,
    input  logic        WR_READY,
    output logic        WR_EN,
    output logic [14:0] WR_ADDR,
    output logic [7:0]  WR_DATA,
    output logic        BUSY
);

    paint_state_t      r_state;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_busy;
    logic              r_pending;
    logic [ADDR_W-1:0] r_sweep;

    logic [7:0]        r_rec_x;
    logic [7:0]        r_rec_y;
    logic [7:0]        r_rec_c;
    logic              r_rec_valid;

    logic [7:0]        r_lat_x;
    logic [7:0]        r_lat_y;
    logic [7:0]        r_lat_c;

    logic [8:0]        w_px;
    logic [8:0]        w_py;
    logic [ADDR_W-1:0] w_addr;
    logic              w_in_bounds;
    logic              w_last_px;
    logic              w_pix_done;
    logic              w_match;
    logic              w_trigger;

`ifdef PAINT_BRUSH2X2_EN
    logic [1:0]        r_idx;

    assign w_px      = {1'b0, r_lat_x} + {8'd0, r_idx[0]};
    assign w_py      = {1'b0, r_lat_y} + {8'd0, r_idx[1]};
    assign w_last_px = (r_idx == 2'd3);

    // brush index walks the 2x2 footprint, one step per finished pixel
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idx <= 2'd0;
        end else if (r_state != ST_PAINT) begin
            r_idx <= 2'd0;
        end else if (w_pix_done) begin
            r_idx <= r_idx + 2'd1;
        end
    end
`else
    assign w_px      = {1'b0, r_lat_x};
    assign w_py      = {1'b0, r_lat_y};
    assign w_last_px = 1'b1;
`endif

    fb_addr_calc u_addr (
        .i_x         (w_px),
        .i_y         (w_py),
        .o_addr      (w_addr),
        .o_in_bounds (w_in_bounds)
    );

    // a pixel is finished when its write is accepted or it is clipped
    assign w_pix_done = r_wr_en ? WR_READY : ~w_in_bounds;
    assign w_match    = r_rec_valid && (r_rec_x == xCoord) &&
                        (r_rec_y == yCoord) && (r_rec_c == RGBw);
    assign w_trigger  = PEN_DOWN && !w_match;

    // main sequencer: state, record, pending clear and registered write port
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 15'd0;
            r_wr_data   <= 8'h00;
            r_busy      <= 1'b0;
            r_pending   <= 1'b0;
            r_sweep     <= 15'd0;
            r_rec_x     <= 8'd0;
            r_rec_y     <= 8'd0;
            r_rec_c     <= 8'd0;
            r_rec_valid <= 1'b0;
            r_lat_x     <= 8'd0;
            r_lat_y     <= 8'd0;
            r_lat_c     <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (CLEAR || r_pending) begin
                        r_state   <= ST_CLEAR;
                        r_busy    <= 1'b1;
                        r_pending <= 1'b0;
                        r_sweep   <= 15'd0;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= 15'd0;
                        r_wr_data <= BG_COLOR;
                    end else if (w_trigger) begin
                        r_state <= ST_PAINT;
                        r_busy  <= 1'b1;
                        r_lat_x <= xCoord;
                        r_lat_y <= yCoord;
                        r_lat_c <= RGBw;
                    end else if (!PEN_DOWN) begin
                        r_rec_valid <= 1'b0;
                    end
                end
                ST_PAINT: begin
                    if (CLEAR) begin
                        r_pending <= 1'b1;
                    end
                    if (r_wr_en) begin
                        if (WR_READY) begin
                            r_wr_en <= 1'b0;
                        end
                    end else if (w_in_bounds) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_addr;
                        r_wr_data <= r_lat_c;
                    end
                    // clipped pixels still count: the record always follows the latch
                    if (w_pix_done && w_last_px) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_rec_x     <= r_lat_x;
                        r_rec_y     <= r_lat_y;
                        r_rec_c     <= r_lat_c;
                        r_rec_valid <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (CLEAR) begin
                        r_pending <= 1'b1;
                    end
                    if (WR_READY) begin
                        if (r_sweep == LAST_ADDR) begin
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_wr_en     <= 1'b0;
                            r_rec_valid <= 1'b0;
                        end else begin
                            r_sweep   <= r_sweep + 15'd1;
                            r_wr_addr <= r_sweep + 15'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign WR_EN   = r_wr_en;
    assign WR_ADDR = r_wr_addr;
    assign WR_DATA = r_wr_data;
    assign BUSY    = r_busy;

endmodule

// File: doc/paint_writer.md
PAINT_WRITER -- requirements
Module: paint_writer

Interface
REQ-001 Parameters (name, default, meaning): none; all geometry constants come from the shared package.
REQ-002 CLK  in  1  single system clock; all logic rises on posedge CLK.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 PEN_DOWN  in  1  level; 1 = paint at cursor.
REQ-005 CLEAR  in  1  single-cycle pulse; request full-screen clear.
REQ-006 xCoord  in  8  cursor column from cursor stage, valid 0..159.
REQ-007 yCoord  in  8  cursor row, valid 0..119.
REQ-008 RGBw  in  8  pen colour, RGB 3-3-2.
REQ-009 WR_READY  in  1  framebuffer accepts the write in this cycle.
REQ-010 WR_EN  out  1  write request to framebuffer.
REQ-011 WR_ADDR  out  15  pixel address.
REQ-012 WR_DATA  out  8  pixel colour.
REQ-013 BUSY  out  1  1 whenever the state is not IDLE.

Function
REQ-014 States: IDLE, PAINT, CLEAR.
REQ-015 Write handshake: a write completes on a cycle with WR_EN=1 and WR_READY=1; while WR_EN=1 and WR_READY=0, WR_ADDR and WR_DATA are held stable.
REQ-016 Address rule: WR_ADDR = y*160 + x, computed as (y<<7)+(y<<5)+x in 15 bits; maximum value 19199.
REQ-017 The block holds a last-painted record {x, y, colour, valid}.
REQ-018 IDLE->PAINT when PAINT_DOWN... PEN_DOWN=1 and the record is not valid or differs from the current {xCoord, yCoord, RGBw}; the block latches the inputs on that transition.
REQ-019 PAINT issues WR_EN in the cycle after entry, using the latched values.
REQ-020 PAINT->IDLE after the last write completes; the record is then updated and marked valid.
REQ-021 Clipping: a pixel with x>159 or y>119 is skipped, with no WR_EN; the record is still updated.
REQ-022 PEN_DOWN=0 in IDLE invalidates the record, so the next pen-down repaints even at the same position.
REQ-023 Latency from input change in IDLE to first WR_EN: 2 cycles.
REQ-024 CLEAR pulse in IDLE -> CLEAR state, which writes BG_COLOR to addresses 0..19199 in ascending order, one per accepted write.
REQ-025 Clear completes after address 19199 is accepted; the state returns to IDLE and the record is invalidated.
REQ-026 A CLEAR pulse while in PAINT or CLEAR sets a pending flag; a pending clear is serviced from IDLE with priority over paint.
REQ-027 Multiple pending pulses collapse into one pending clear.
REQ-028 When CLEAR and a paint condition are both present in IDLE, CLEAR wins and the paint is re-evaluated afterwards.
REQ-029 Input changes during PAINT are ignored; the latched values are used until PAINT exits.

Reset
REQ-030 RST=1 forces, asynchronously: state IDLE, WR_EN=0, WR_ADDR=0, WR_DATA=0, BUSY=0, record invalid, pending clear=0, sweep counter=0.
REQ-031 Reset asserted mid-PAINT or mid-CLEAR abandons the operation; after release no write resumes without a new trigger.

Configuration
REQ-032 Macro PAINT_BRUSH2X2_EN.
- Defined: PAINT issues up to 4 writes, in order (x,y), (x+1,y), (x,y+1), (x+1,y+1), each clipped per REQ-021 independently; a 2-bit brush index sequences them.
- Undefined: PAINT issues a single write at (x,y).

Structure
REQ-033 Package paint_pkg holds:
- H_RES=160, V_RES=120, FB_DEPTH=19200, ADDR_W=15
- BG_COLOR=8'h00
- the paint_state_t enum
REQ-034 Sub-module fb_addr_calc: combinational; takes x and y, returns 15-bit address and in_bounds flag; one instance shared by PAINT and CLEAR is not required.

Verification
REQ-035 PEN_DOWN=1, x=10, y=5, RGBw=8'hE0, WR_READY=1 -> one write, WR_ADDR=810, WR_DATA=8'hE0; same inputs held 100 cycles -> no further writes.
REQ-036 x=159, y=119 with PAINT_BRUSH2X2_EN defined -> exactly one write at 19199; with x=158, y=118 -> addresses 19038, 19039, 19198, 19199.
REQ-037 WR_READY held 0 for 7 cycles during a paint -> WR_ADDR and WR_DATA stable for those 7 cycles; the write completes on the cycle WR_READY rises.
REQ-038 CLEAR pulse with WR_READY=1 -> 19200 writes of 8'h00 at addresses 0..19199, BUSY=1 throughout; a second CLEAR mid-sweep -> exactly one further full sweep.
REQ-039 RST asserted at clear address 5000 -> WR_EN=0 and BUSY=0 immediately, with no writes after release until a new trigger.
REQ-040 PEN_DOWN toggles 1->0->1 at an unchanged position -> a second write is issued to the same address.
